nibble_serial_add_seq: RTL and testbench

NIBBLE_SERIAL_ADD_SEQ -- requirements
Module: nibble_serial_add_seq

---
 rtl/nibble_serial_add_seq.sv | 115 +++++++++++
 tb/tb_nibble_serial_add_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_seq.sv
// Nibble-serial adder/subtractor: sequences WIDTH/4 passes through an external 4-bit
// carry-lookahead slice, one nibble per clock, LSB nibble first.
module nibble_serial_add_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin_in,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  carry_q, carry_d;
  logic [N-1:0][3:0]     a_q, a_d;
  logic [N-1:0][3:0]     b_q, b_d;
  logic [N-1:0][3:0]     result_q, result_d;
  logic                  cout_q, cout_d;
  logic                  ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      k_q      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Subtraction is A + ~B + 1, so B is inverted and the carry forced to one.
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub ? 1'b1 : cin_in;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d[k_q] = add_sum;
        carry_d       = add_cout;
        k_d           = k_q + KW'(1);
        if (k_q == KLast) begin
          cout_d  = add_cout;
          ovf_d   = (a_q[N-1][3] == b_q[N-1][3]) && (add_sum[3] != a_q[N-1][3]);
          k_d     = '0;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_q == StRun) begin
      add_a   = a_q[k_q];
      add_b   = b_q[k_q];
      add_cin = carry_q;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Directed bench for nibble_serial_add_seq: a behavioural 4-bit CLA stands in for the
// external slice, and each operation is checked per cycle and at completion.
module tb_nibble_serial_add_seq;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin_in;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nibble_serial_add_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .cin_in   (cin_in),
    .op_a     (op_a),
    .op_b     (op_b),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .ovf      (ovf)
  );

  // Returns {cout, sum} of a 4-bit carry-lookahead adder.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g, p;
    logic [4:0] c;
    g = a & b;
    p = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  always_comb {add_cout, add_sum} = cla4(add_a, add_b, add_cin);

  // Runs one operation from IDLE; leaves the bench 1 time unit after an edge, back in IDLE.
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic ci, input logic [W-1:0] exp_res,
                       input logic exp_cout, input logic exp_ovf);
    logic [W-1:0] beff;
    logic         carry;
    logic [4:0]   cs;
    beff  = s ? ~b : b;
    carry = s ? 1'b1 : ci;
    start = 1'b1; sub = s; cin_in = ci; op_a = a; op_b = b;
    @(posedge clk); #1;
    // Scramble inputs during RUN; they must not leak into the result.
    start = 1'b0; sub = ~s; cin_in = ~ci; op_a = ~a; op_b = 16'h5A5A;
    for (int k = 0; k < N; k++) begin
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL %s run%0d busy/done: got %b/%b want 1/0", name, k, busy, done);
      end
      tests++;
      if (add_a !== a[4*k +: 4] || add_b !== beff[4*k +: 4] || add_cin !== carry) begin
        fails++;
        $display("FAIL %s slice%0d a/b/cin: got %h/%h/%b want %h/%h/%b", name, k,
                 add_a, add_b, add_cin, a[4*k +: 4], beff[4*k +: 4], carry);
      end
      cs    = cla4(a[4*k +: 4], beff[4*k +: 4], carry);
      carry = cs[4];
      @(posedge clk); #1;
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s done_cycle busy/done: got %b/%b want 0/1", name, busy, done);
    end
    tests++;
    if (result !== exp_res || cout !== exp_cout || ovf !== exp_ovf) begin
      fails++;
      $display("FAIL %s result/cout/ovf: got %h/%b/%b want %h/%b/%b", name, result, cout,
               ovf, exp_res, exp_cout, exp_ovf);
    end
    tests++;
    if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      fails++;
      $display("FAIL %s slice_idle_in_done: got %h/%h/%b want 0/0/0", name, add_a, add_b,
               add_cin);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
      fails++;
      $display("FAIL %s after_done busy/done/result: got %b/%b/%h want 0/0/%h", name, busy,
               done, result, exp_res);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin_in = 1'b0; op_a = '0; op_b = '0;
    #3;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || ovf !== 1'b0 ||
        add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      fails++;
      $display("FAIL reset outputs: busy %b done %b result %h cout %b ovf %b slice %h/%h/%b",
               busy, done, result, cout, ovf, add_a, add_b, add_cin);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_ovf",   16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (result !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL hold_in_idle: got %h/%b/%b want 8000/0/1", result, cout, ovf);
    end
  endtask

  task automatic test_sub();
    do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
  endtask

  // start stays high and operands change every cycle; accepts happen at edges 0, 6, 12.
  task automatic test_back_to_back();
    logic [W-1:0] exp_tab [3];
    exp_tab[0] = 16'h1020;
    exp_tab[1] = 16'h168C;
    exp_tab[2] = 16'h1CF8;
    sub = 1'b0; cin_in = 1'b0;
    for (int cyc = 0; cyc <= 17; cyc++) begin
      start = (cyc <= 12);
      op_a  = 16'h1000 + W'(cyc) * 16'h0111;
      op_b  = 16'h0020 + W'(cyc);
      @(posedge clk); #1;
      if (cyc % 6 == 4) begin
        tests++;
        if (done !== 1'b1 || result !== exp_tab[cyc / 6] || cout !== 1'b0 || ovf !== 1'b0)
        begin
          fails++;
          $display("FAIL b2b_op%0d done/result/cout/ovf: got %b/%h/%b/%b want 1/%h/0/0",
                   cyc / 6, done, result, cout, ovf, exp_tab[cyc / 6]);
        end
      end else if (cyc % 6 == 5) begin
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          fails++;
          $display("FAIL b2b_gap%0d busy/done: got %b/%b want 0/0", cyc, busy, done);
        end
      end else if (cyc <= 16) begin
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          fails++;
          $display("FAIL b2b_run%0d busy/done: got %b/%b want 1/0", cyc, busy, done);
        end
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic saw_done;
    start = 1'b1; sub = 1'b0; cin_in = 1'b0; op_a = 16'h1234; op_b = 16'h1111;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || ovf !== 1'b0 ||
        add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0) begin
      fails++;
      $display("FAIL mid_run_reset outputs: busy %b done %b result %h cout %b ovf %b", busy,
               done, result, cout, ovf);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    tests++;
    if (saw_done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_run_no_done: saw_done %b busy %b want 0/0", saw_done, busy);
    end
    do_op("after_reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
